calc_param_core: RTL and testbench

- Parametrised next-generation calculator core: decimal keypad commands in, NDIGITS seven-segment digits plus 2-bit status out.
- Adds over the current calculator: valid-qualified commands, subtraction with signed results, iterative multiplication, left-to-right chained operations, overflow/error state, and multi-cycle BCD↔binary conversion.
- Sits between the keypad command decoder and the display drivers.

---
 rtl/calc_param_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_calc_param_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_param_core.sv
// Keypad-driven decimal calculator core: serial BCD->binary load, add/sub or
// shift-add multiply, double-dabble back to BCD. Define CALC_BACKSPACE_EN for backspace.
module calc_param_core #(
  parameter int NDIGITS = 8,
  parameter int DATA_W  = 27
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] cmd_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic [6:0] displays_o [NDIGITS],
  output logic [1:0] status_o
);

  // state    | meaning
  // S_ENTRY  | taking digits/operators; shows entry, or acc right after an operator
  // S_LOAD   | BCD->binary of entry (and of acc while it is still BCD), one digit/cycle
  // S_EXEC   | add/sub in one cycle, or shift-add multiply over DATA_W cycles
  // S_CONV   | double-dabble of the result magnitude back to BCD
  // S_RESULT | showing acc after '='
  // S_ERROR  | overflow; only clear or reset leaves

  localparam int BW = 4 * NDIGITS;
  localparam int PW = 2 * DATA_W;
  localparam int AW = DATA_W + 1;
  localparam int SW = DATA_W + 2;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [PW-1:0] MAX_POS = PW'(10 ** NDIGITS - 1);
  localparam logic [PW-1:0] MAX_NEG = PW'(10 ** (NDIGITS - 1) - 1);
  localparam logic [3:0] CMD_ADD = 4'hA;
  localparam logic [3:0] CMD_SUB = 4'hB;
  localparam logic [3:0] CMD_MUL = 4'hC;
  localparam logic [3:0] CMD_EQ  = 4'hE;
  localparam logic [3:0] CMD_CLR = 4'hF;
`ifdef CALC_BACKSPACE_EN
  localparam logic [3:0] CMD_BSP = 4'hD;
`endif

  typedef enum logic [2:0] {S_ENTRY, S_LOAD, S_EXEC, S_CONV, S_RESULT, S_ERROR} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t            state_q;
  op_t               pend_q, op_q, nxt_pend_q;
  logic [BW-1:0]     entry_q, acc_bcd_q, disp_bcd_q, ld_e_q, ld_a_q, bcd_q;
  logic [3:0]        cnt_dig_q;
  logic              seen_q, acc_is_bcd_q, disp_neg_q, to_result_q, res_neg_q, err_q;
  logic [AW-1:0]     acc_q, opa_q;
  logic [DATA_W-1:0] lb_e_q, lb_a_q, ope_q, mplier_q, bin_q, res_mag_q;
  logic [PW-1:0]     mcand_q, prod_q;
  logic [CW-1:0]     cnt_q;

  logic              accept, is_digit, is_op, is_eq, do_clear, start_cmp;
  op_t               new_op;
  logic [DATA_W-1:0] lb_e_d, lb_a_d, opa_mag_d;
  logic [AW-1:0]     opa_d, acc_res_d;
  logic [SW-1:0]     sum_d, sum_mag_d;
  logic [PW-1:0]     prod_d, ex_mag_d;
  logic              ex_neg_d, ex_err_d;
  logic [BW-1:0]     bcd_adj_d, bcd_d, entry_shl_d;

  assign cmd_ready_o = !(state_q inside {S_LOAD, S_EXEC, S_CONV});

  always_comb begin
    accept    = cmd_valid_i && cmd_ready_o;
    is_digit  = cmd_i <= 4'd9;
    is_op     = (cmd_i == CMD_ADD) || (cmd_i == CMD_SUB) || (cmd_i == CMD_MUL);
    is_eq     = cmd_i == CMD_EQ;
    do_clear  = accept && (cmd_i == CMD_CLR);
    start_cmp = accept && (state_q == S_ENTRY) && (is_op || is_eq) &&
                (pend_q != OP_NONE) && seen_q;
    case (cmd_i)
      CMD_ADD: new_op = OP_ADD;
      CMD_SUB: new_op = OP_SUB;
      CMD_MUL: new_op = OP_MUL;
      default: new_op = OP_NONE;
    endcase
  end

  always_comb begin
    lb_e_d    = (lb_e_q << 3) + (lb_e_q << 1) + DATA_W'(ld_e_q[BW-1 -: 4]);
    lb_a_d    = (lb_a_q << 3) + (lb_a_q << 1) + DATA_W'(ld_a_q[BW-1 -: 4]);
    // acc entered as BCD is converted alongside the entry, so it costs no extra cycles
    opa_d     = acc_is_bcd_q ? {1'b0, lb_a_d} : acc_q;
    opa_mag_d = opa_d[AW-1] ? (~opa_d[DATA_W-1:0] + DATA_W'(1)) : opa_d[DATA_W-1:0];
    sum_d     = (op_q == OP_SUB) ? ({opa_q[AW-1], opa_q} - {2'b00, ope_q})
                                 : ({opa_q[AW-1], opa_q} + {2'b00, ope_q});
    sum_mag_d = sum_d[SW-1] ? (~sum_d + SW'(1)) : sum_d;
    prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
    if (op_q == OP_MUL) begin
      ex_mag_d = prod_d;
      ex_neg_d = opa_q[AW-1] && (ope_q != '0);
    end else begin
      ex_mag_d = PW'(sum_mag_d);
      ex_neg_d = sum_d[SW-1];
    end
    ex_err_d  = ex_neg_d ? (ex_mag_d > MAX_NEG) : (ex_mag_d > MAX_POS);
    bcd_adj_d = bcd_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d       = {bcd_adj_d[BW-2:0], bin_q[DATA_W-1]};
    entry_shl_d = {entry_q[BW-5:0], cmd_i};
    acc_res_d   = res_neg_q ? (~{1'b0, res_mag_q} + AW'(1)) : {1'b0, res_mag_q};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || do_clear) begin
      state_q      <= S_ENTRY;
      pend_q       <= OP_NONE;
      op_q         <= OP_NONE;
      nxt_pend_q   <= OP_NONE;
      entry_q      <= '0;
      acc_bcd_q    <= '0;
      disp_bcd_q   <= '0;
      ld_e_q       <= '0;
      ld_a_q       <= '0;
      bcd_q        <= '0;
      cnt_dig_q    <= '0;
      seen_q       <= 1'b0;
      acc_is_bcd_q <= 1'b0;
      disp_neg_q   <= 1'b0;
      to_result_q  <= 1'b0;
      res_neg_q    <= 1'b0;
      err_q        <= 1'b0;
      acc_q        <= '0;
      opa_q        <= '0;
      lb_e_q       <= '0;
      lb_a_q       <= '0;
      ope_q        <= '0;
      mplier_q     <= '0;
      bin_q        <= '0;
      res_mag_q    <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_ENTRY, S_RESULT: begin
          if (start_cmp) begin
            ld_e_q      <= entry_q;
            ld_a_q      <= acc_bcd_q;
            lb_e_q      <= '0;
            lb_a_q      <= '0;
            op_q        <= pend_q;
            nxt_pend_q  <= new_op;
            to_result_q <= is_eq;
            entry_q     <= '0;
            cnt_dig_q   <= '0;
            seen_q      <= 1'b0;
            cnt_q       <= CW'(NDIGITS - 1);
            state_q     <= S_LOAD;
          end else if (accept && is_digit) begin
            seen_q     <= 1'b1;
            disp_neg_q <= 1'b0;
            if (state_q == S_RESULT) begin
              entry_q      <= BW'(cmd_i);
              cnt_dig_q    <= (cmd_i != 4'd0) ? 4'd1 : 4'd0;
              disp_bcd_q   <= BW'(cmd_i);
              acc_q        <= '0;
              acc_bcd_q    <= '0;
              acc_is_bcd_q <= 1'b0;
              pend_q       <= OP_NONE;
              state_q      <= S_ENTRY;
            end else if (cnt_dig_q != 4'(NDIGITS) && (cnt_dig_q != 4'd0 || cmd_i != 4'd0)) begin
              entry_q    <= entry_shl_d;
              cnt_dig_q  <= cnt_dig_q + 4'd1;
              disp_bcd_q <= entry_shl_d;
            end else begin
              disp_bcd_q <= entry_q;
            end
          end else if (accept && (is_op || is_eq)) begin
            // no compute: acc takes the entry (still BCD) or is kept; display already shows it
            if (state_q == S_ENTRY && pend_q == OP_NONE) begin
              acc_bcd_q    <= entry_q;
              acc_is_bcd_q <= 1'b1;
            end
            pend_q    <= new_op;
            entry_q   <= '0;
            cnt_dig_q <= '0;
            seen_q    <= 1'b0;
            state_q   <= is_eq ? S_RESULT : S_ENTRY;
          end
`ifdef CALC_BACKSPACE_EN
          else if (accept && cmd_i == CMD_BSP && state_q == S_ENTRY && cnt_dig_q != 4'd0) begin
            entry_q    <= entry_q >> 4;
            disp_bcd_q <= entry_q >> 4;
            cnt_dig_q  <= cnt_dig_q - 4'd1;
          end
`endif
        end
        S_LOAD: begin
          lb_e_q <= lb_e_d;
          lb_a_q <= lb_a_d;
          ld_e_q <= ld_e_q << 4;
          ld_a_q <= ld_a_q << 4;
          if (cnt_q == '0) begin
            opa_q    <= opa_d;
            ope_q    <= lb_e_d;
            mcand_q  <= PW'(opa_mag_d);
            mplier_q <= lb_e_d;
            prod_q   <= '0;
            cnt_q    <= (op_q == OP_MUL) ? CW'(DATA_W - 1) : '0;
            state_q  <= S_EXEC;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_EXEC: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            err_q     <= ex_err_d;
            res_neg_q <= ex_neg_d;
            res_mag_q <= ex_mag_d[DATA_W-1:0];
            bin_q     <= ex_mag_d[DATA_W-1:0];
            bcd_q     <= '0;
            cnt_q     <= CW'(DATA_W - 1);
            state_q   <= S_CONV;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          err_q <= err_q | bcd_adj_d[BW-1];
          if (cnt_q == '0) begin
            if (err_q || bcd_adj_d[BW-1]) begin
              state_q <= S_ERROR;
            end else begin
              acc_q        <= acc_res_d;
              acc_is_bcd_q <= 1'b0;
              disp_bcd_q   <= bcd_d;
              disp_neg_q   <= res_neg_q;
              pend_q       <= nxt_pend_q;
              state_q      <= to_result_q ? S_RESULT : S_ENTRY;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_ENTRY;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      displays_o[i] = 7'b0000000;
      if (state_q == S_ERROR) begin
        if (i == 0) displays_o[i] = 7'b1111001;
      end else begin
        if (disp_bcd_q[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
        if (!lead) displays_o[i] = seg7(disp_bcd_q[4*i +: 4]);
        else if (i == NDIGITS - 1 && disp_neg_q) displays_o[i] = 7'b1000000;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_ENTRY:  status_o = 2'b00;
      S_RESULT: status_o = 2'b10;
      S_ERROR:  status_o = 2'b11;
      default:  status_o = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_calc_param_core.sv
// Directed bench for calc_param_core (NDIGITS=8, DATA_W=27) with hand-computed results.
module tb_calc_param_core;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] displays [8];
  logic [1:0] status;
  logic [55:0] disp_flat;

  int n_checks = 0;
  int n_err = 0;

  localparam logic [55:0] SEGS_ERR = 56'h79;

  calc_param_core #(.NDIGITS(8), .DATA_W(27)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .cmd_i      (cmd),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .displays_o (displays),
    .status_o   (status)
  );

  always #5 clock = ~clock;

  always_comb begin
    disp_flat = '0;
    for (int i = 0; i < 8; i++) disp_flat[7*i +: 7] = displays[i];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [55:0] exp_segs(input longint v);
    logic [55:0] f;
    longint m;
    f = '0;
    m = (v < 0) ? -v : v;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || m != 0) f[7*i +: 7] = seg_of(int'(m % 10));
      m = m / 10;
    end
    if (v < 0) f[55:49] = 7'b1000000;
    return f;
  endfunction

  task automatic wait_idle();
    int w;
    w = 0;
    while (status == 2'b01 && w < 400) begin
      @(negedge clock);
      w++;
    end
    if (status == 2'b01) begin
      n_checks++;
      n_err++;
      $display("FAIL busy_timeout: status still 01 after 400 cycles, required idle");
    end
  endtask

  task automatic send(input logic [3:0] c);
    int w;
    w = 0;
    @(negedge clock);
    while (!cmd_ready && w < 400) begin
      @(negedge clock);
      w++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: cmd_ready low after 400 cycles, required high");
    end
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte ch;
      logic [3:0] c;
      ch = s[i];
      case (ch)
        "+": c = 4'hA;
        "-": c = 4'hB;
        "*": c = 4'hC;
        "<": c = 4'hD;
        "=": c = 4'hE;
        "C": c = 4'hF;
        default: c = 4'(ch - 8'd48);
      endcase
      send(c);
    end
    wait_idle();
  endtask

  initial begin
    int n_busy;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_status", 64'(status), 64'(0));
    chk("reset_ready", 64'(cmd_ready), 64'(1));
    chk("reset_disp", 64'(disp_flat), 64'(exp_segs(0)));

    keys("1234+");
    chk("op_shows_acc", 64'(disp_flat), 64'(exp_segs(1234)));
    keys("1234=");
    chk("add_status", 64'(status), 64'(2));
    chk("add_disp", 64'(disp_flat), 64'(exp_segs(2468)));

    keys("C5-9=");
    chk("sub_status", 64'(status), 64'(2));
    chk("sub_disp", 64'(disp_flat), 64'(exp_segs(-4)));

    keys("C12*34");
    send(4'hE);
    n_busy = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (status == 2'b01 && !cmd_ready) n_busy++;
      else break;
      if (n_busy == 10) begin
        cmd = 4'hA;
        cmd_valid = 1'b1;
      end
      if (n_busy == 11) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("mul_busy_cycles", 64'(n_busy), 64'(62));
    chk("mul_status", 64'(status), 64'(2));
    chk("mul_disp", 64'(disp_flat), 64'(exp_segs(408)));

    keys("C2+3*");
    chk("chain_mid_status", 64'(status), 64'(0));
    chk("chain_mid_disp", 64'(disp_flat), 64'(exp_segs(5)));
    keys("4=");
    chk("chain_disp", 64'(disp_flat), 64'(exp_segs(20)));

    keys("6");
    chk("result_digit_status", 64'(status), 64'(0));
    chk("result_digit_disp", 64'(disp_flat), 64'(exp_segs(6)));
    keys("=+1=");
    chk("result_reuse_disp", 64'(disp_flat), 64'(exp_segs(7)));

    keys("C999999999");
    chk("full_entry_disp", 64'(disp_flat), 64'(exp_segs(99999999)));
    keys("+1=");
    chk("ovf_status", 64'(status), 64'(3));
    chk("ovf_disp", 64'(disp_flat), 64'(SEGS_ERR));
    keys("5+");
    chk("err_ignore_status", 64'(status), 64'(3));
    chk("err_ignore_disp", 64'(disp_flat), 64'(SEGS_ERR));
    keys("C");
    chk("clear_status", 64'(status), 64'(0));
    chk("clear_disp", 64'(disp_flat), 64'(exp_segs(0)));

    keys("+-7=");
    chk("op_replace_disp", 64'(disp_flat), 64'(exp_segs(-7)));
    keys("*3=");
    chk("neg_mul_disp", 64'(disp_flat), 64'(exp_segs(-21)));
    keys("*1000000=");
    chk("neg_ovf_status", 64'(status), 64'(3));

    keys("C-9999999=");
    chk("neg_limit_status", 64'(status), 64'(2));
    chk("neg_limit_disp", 64'(disp_flat), 64'(exp_segs(-9999999)));

    keys("C005");
    chk("lead_zero_disp", 64'(disp_flat), 64'(exp_segs(5)));
    keys("*0=");
    chk("mul_zero_disp", 64'(disp_flat), 64'(exp_segs(0)));
    chk("mul_zero_status", 64'(status), 64'(2));

    keys("C123<");
`ifdef CALC_BACKSPACE_EN
    chk("backspace_disp", 64'(disp_flat), 64'(exp_segs(12)));
`else
    chk("backspace_disp", 64'(disp_flat), 64'(exp_segs(123)));
`endif

    keys("C1+1");
    send(4'hE);
    repeat (5) @(negedge clock);
    chk("mid_busy_status", 64'(status), 64'(1));
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_status", 64'(status), 64'(0));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    chk("abort_disp", 64'(disp_flat), 64'(exp_segs(0)));
    repeat (3) @(negedge clock);
    chk("abort_stays_status", 64'(status), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
